// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_n_pkg;

  // 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_n_if.sv
// start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/serial_adder_n_fa_1bit.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, one bit per clock, LSB first.
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one operand bit pair added per clock, busy=1
// DONE  | single cycle with done=1, results just updated
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_n_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic             carry_ff;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  fa_1bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry_ff),
    .s   (fa_s),
    .co  (fa_co)
  );

  // The new sum bit enters at the MSB; on the last bit this is the full result word.
  assign res_next = {fa_s, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      carry_ff   <= 1'b0;
      cnt        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            carry_ff <= bus.cin;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          res      <= res_next[WIDTH-1:1];
          carry_ff <= fa_co;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum_q      <= res_next;
            cout_q     <= fa_co;
            // carry_ff still holds the carry into the MSB here
            overflow_q <= carry_ff ^ fa_co;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n (WIDTH=8): stimulus queues expected results, a monitor checks each done.
module tb_serial_adder_n;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  serial_adder_n_if #(.WIDTH(8)) bus ();

  serial_adder_n #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  function automatic exp_t ref_model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return mk(t[7:0], t[8], (x[7] == y[7]) && (t[7] != x[7]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        checks++;
        got = mk(bus.sum, bus.cout, bus.overflow);
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: sum=%0h cout=%0b ovf=%0b with nothing pending",
                   got.sum, got.cout, got.ovf);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result: got sum=%0h cout=%0b ovf=%0b, expected sum=%0h cout=%0b ovf=%0b",
                     got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(output int busy_cnt);
    logic seen;
    seen = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  // Called just after a negedge with the DUT in IDLE; returns at the negedge where done=1.
  task automatic run_add(input logic [7:0] x, input logic [7:0] y, input logic c, input exp_t e);
    int bc;
    bus.a = x; bus.b = y; bus.cin = c; bus.start = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
    wait_done(bc);
    chk("busy_len", 32'(bc), 32'd8);
  endtask

  initial begin
    int bc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_add(8'h5A, 8'h3C, 1'b0, mk(8'h96, 1'b0, 1'b1));
    @(negedge clk);
    run_add(8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0));
    @(negedge clk);
    run_add(8'h80, 8'h80, 1'b0, mk(8'h00, 1'b1, 1'b1));
    @(negedge clk);
    run_add(8'h00, 8'h00, 1'b1, mk(8'h01, 1'b0, 1'b0));

    // start held from the done cycle: ignored in DONE, accepted in the following IDLE cycle
    bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b0; bus.start = 1'b1;
    q.push_back(mk(8'h77, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_busy_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy_rise", 32'(bus.busy), 32'd1);
    wait_done(bc);
    chk("b2b_busy_len", 32'(bc), 32'd7);
    @(negedge clk);

    // start during RUN must be ignored; no second done may follow
    bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    q.push_back(mk(8'h10, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.a = 8'h11; bus.b = 8'h22; bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc);
    repeat (12) @(negedge clk);
    chk("ignored_start_sum", 32'(bus.sum), 32'h10);

    // asynchronous reset at cnt=4 discards the addition
    bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    chk("arst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_add(8'h12, 8'h34, 1'b0, mk(8'h46, 1'b0, 1'b0));

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_add(ra, rb, rc, ref_model(ra, rb, rc));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
